// File: rtl/mpu_load_stream.sv
// mpu_load_stream: takes a row-major matrix as a valid/ready stream of
// LANES-element beats and writes it into a matrix register, one element
// per cycle, with explicit row/column indices.
// Ports: clk, rst (async, active high); en + matrix_m_size/matrix_n_size/
//   load_addr start a load; in_valid/in_ready/in_elements carry beats
//   (lane 0 = earliest); busy/ack/error report status; reg_* drive the
//   register-file write port and the latched size/address.
// Optional: define MPU_LOAD_TRANSPOSE_EN to add the transpose input.
module mpu_load_stream #(
  parameter int FP     = 32,
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int LANES  = 2,
  parameter int REGS   = 8,
  parameter int MBITS  = $clog2(M),
  parameter int NBITS  = $clog2(N),
  parameter int ADDR_W = $clog2(REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [MBITS:0]        matrix_m_size,
  input  logic [NBITS:0]        matrix_n_size,
  input  logic [ADDR_W-1:0]     load_addr,
`ifdef MPU_LOAD_TRANSPOSE_EN
  input  logic                  transpose,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*FP-1:0]   in_elements,
  output logic                  busy,
  output logic                  ack,
  output logic                  error,
  output logic                  reg_write_en,
  output logic [ADDR_W-1:0]     reg_load_addr,
  output logic [FP-1:0]         reg_element_out,
  output logic [MBITS-1:0]      reg_i,
  output logic [NBITS-1:0]      reg_j,
  output logic [MBITS:0]        reg_m_out,
  output logic [NBITS:0]        reg_n_out
);

  localparam int CW = (MBITS > NBITS) ? MBITS : NBITS;
  localparam int TW = MBITS + NBITS + 2;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE, FILL, DRAIN, DONE
  } state_t;

  state_t state_q, state_d;

  logic [MBITS:0]       m_q;
  logic [NBITS:0]       n_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [CW-1:0]        i_q, j_q;
  logic [TW-1:0]        k_q, total;
  logic [LW-1:0]        lane_q;
  logic [LANES*FP-1:0]  buf_q;
  logic                 error_q;
  logic                 tr_q, start_tr;
  logic                 start_bad, start_ok;
  logic                 accept, last_el, last_lane, j_wrap;

`ifdef MPU_LOAD_TRANSPOSE_EN
  assign start_tr = transpose;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tr_q <= 1'b0;
    else if (start_ok)
      tr_q <= start_tr;
  end
`else
  assign start_tr = 1'b0;
  assign tr_q     = 1'b0;
`endif

  // A transposed load lands as n x m, so the bounds swap.
  always_comb begin
    start_bad = (matrix_m_size == '0) || (matrix_n_size == '0) ||
                (32'(load_addr) >= REGS);
    if (start_tr)
      start_bad = start_bad || (32'(matrix_n_size) > M) ||
                  (32'(matrix_m_size) > N);
    else
      start_bad = start_bad || (32'(matrix_m_size) > M) ||
                  (32'(matrix_n_size) > N);
  end

  assign start_ok  = (state_q == IDLE) && en && !start_bad;
  assign total     = TW'(m_q) * TW'(n_q);
  assign last_el   = (k_q == total - TW'(1));
  assign last_lane = (lane_q == LW'(LANES - 1));
  assign j_wrap    = (32'(j_q) + 1) == 32'(n_q);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_ok) state_d = FILL;
      FILL:  if (accept) state_d = DRAIN;
      DRAIN: begin
        if (last_el)
          state_d = DONE;
        else if (last_lane && !accept)
          state_d = FILL;
      end
      DONE:  state_d = IDLE;
    endcase
  end

  // The last lane of a non-final beat can take the next beat directly,
  // keeping writes gapless.
  always_comb begin
    in_ready     = 1'b0;
    busy         = 1'b0;
    ack          = 1'b0;
    reg_write_en = 1'b0;
    unique case (state_q)
      IDLE:  ;
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DRAIN: begin
        in_ready     = last_lane && !last_el;
        busy         = 1'b1;
        reg_write_en = 1'b1;
      end
      DONE:  ack = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= (state_q == IDLE) && en && start_bad;
      if (start_ok) begin
        m_q    <= matrix_m_size;
        n_q    <= matrix_n_size;
        addr_q <= load_addr;
        i_q    <= '0;
        j_q    <= '0;
        k_q    <= '0;
      end
      if (accept) begin
        buf_q  <= in_elements;
        lane_q <= '0;
      end else if (state_q == DRAIN && !last_lane) begin
        lane_q <= lane_q + LW'(1);
      end
      if (state_q == DRAIN) begin
        k_q <= k_q + TW'(1);
        if (j_wrap) begin
          j_q <= '0;
          i_q <= i_q + CW'(1);
        end else begin
          j_q <= j_q + CW'(1);
        end
      end
    end
  end

  assign error           = error_q;
  assign reg_load_addr   = addr_q;
  assign reg_element_out = buf_q[int'(lane_q)*FP +: FP];
  assign reg_i           = tr_q ? MBITS'(j_q) : MBITS'(i_q);
  assign reg_j           = tr_q ? NBITS'(i_q) : NBITS'(j_q);
  assign reg_m_out       = tr_q ? (MBITS+1)'(n_q) : m_q;
  assign reg_n_out       = tr_q ? (NBITS+1)'(m_q) : n_q;

endmodule
